// File: rtl/hazard_stall_controller.sv
// Pipeline hazard/stall sequencer for the 5-stage MIPS core: load-use stalls, branch flushes, memory waits.
// Define HAZARD_STALL_STATS_EN to add the saturating stall_count statistics output.
module hazard_stall_controller #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       branch_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       idex_write,
  output logic       exmem_write,
  output logic       idex_bubble,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       mem_timeout,
  output logic [1:0] ctrl_state
`ifdef HAZARD_STALL_STATS_EN
  ,
  output logic [15:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_FLUSH    = 2'b10
  } state_e;

  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_VAL  = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [1:0] flush_cnt_q, flush_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q, timeout_d;

  logic memstall, loaduse;
  logic pc_w, ifid_w, idex_w, exmem_w, bubble, flush;

  assign memstall = mem_req & ~mem_ready;
  assign loaduse  = ex_mem_read & (ex_rt != 5'd0) &
                    ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    pc_w        = 1'b1;
    ifid_w      = 1'b1;
    idex_w      = 1'b1;
    exmem_w     = 1'b1;
    bubble      = 1'b0;
    flush       = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (memstall) begin
          {pc_w, ifid_w, idex_w, exmem_w} = 4'b0000;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else if (branch_taken) begin
          // The ID instruction is on the wrong path, so a coincident load-use is dropped.
          flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_RELOAD;
          end
        end else if (loaduse) begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          bubble = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        if (wait_cnt_q == TIMEOUT_VAL) timeout_d = 1'b1;
        if (mem_ready) begin
          state_d = ST_RUN;
        end else begin
          {pc_w, ifid_w, idex_w, exmem_w} = 4'b0000;
          if (wait_cnt_q != 8'hFF) wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      ST_FLUSH: begin
        if (memstall) begin
          {pc_w, ifid_w, idex_w, exmem_w} = 4'b0000;
        end else begin
          flush = 1'b1;
          if (branch_taken) begin
            flush_cnt_d = FLUSH_RELOAD;
          end else begin
            flush_cnt_d = flush_cnt_q - 2'd1;
            if (flush_cnt_q <= 2'd1) state_d = ST_RUN;
          end
        end
      end

      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 2'd0;
      wait_cnt_q  <= 8'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Outputs are forced low while reset is held; state and timeout are already cleared.
  assign pc_write    = pc_w    & ~reset;
  assign ifid_write  = ifid_w  & ~reset;
  assign idex_write  = idex_w  & ~reset;
  assign exmem_write = exmem_w & ~reset;
  assign idex_bubble = bubble  & ~reset;
  assign ifid_flush  = flush   & ~reset;
  assign idex_flush  = flush   & ~reset;
  assign mem_timeout = timeout_q;
  assign ctrl_state  = state_q;

`ifdef HAZARD_STALL_STATS_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
    end else if (!pc_write && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed, scoreboard-checked bench for hazard_stall_controller (FLUSH_CYCLES=2, MEM_TIMEOUT=4).
module tb_hazard_stall_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, branch_taken, mem_req, mem_ready;
  logic       pc_write, ifid_write, idex_write, exmem_write;
  logic       idex_bubble, ifid_flush, idex_flush, mem_timeout;
  logic [1:0] ctrl_state;
`ifdef HAZARD_STALL_STATS_EN
  logic [15:0] stall_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];

  localparam logic [1:0] RUN = 2'b00, MW = 2'b01, FL = 2'b10;
  localparam logic [3:0] EN_ALL = 4'b1111, EN_NONE = 4'b0000, EN_LU = 4'b0011;

  hazard_stall_controller #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .mem_timeout(mem_timeout), .ctrl_state(ctrl_state)
`ifdef HAZARD_STALL_STATS_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  // {pc, ifid, idex, exmem} enables, bubble, both flushes, timeout, state.
  function automatic logic [9:0] ev(input logic [3:0] en, input logic bub, input logic fl,
                                    input logic to, input logic [1:0] st);
    return {en, bub, fl, fl, to, st};
  endfunction

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic mr, input logic [4:0] ert, input logic br,
                       input logic mq, input logic rdy);
    id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_mem_read = mr;
    ex_rt = ert; branch_taken = br; mem_req = mq; mem_ready = rdy;
  endtask

  task automatic cmp(input string tag);
    logic [9:0] obs, want;
    obs  = {pc_write, ifid_write, idex_write, exmem_write, idex_bubble,
            ifid_flush, idex_flush, mem_timeout, ctrl_state};
    want = exp_q.pop_front();
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, want);
    end
  endtask

  // Called at posedge+1; samples mid-cycle, then advances to the next posedge+1.
  task automatic step(input string tag, input logic [9:0] want);
    exp_q.push_back(want);
    #3;
    cmp(tag);
    @(posedge clk);
    #1;
  endtask

`ifdef HAZARD_STALL_STATS_EN
  task automatic chk_stats(input string tag, input logic [15:0] want);
    n_cmp++;
    assert (stall_count === want) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, stall_count, want);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(ev(EN_NONE, 1'b0, 1'b0, 1'b0, RUN));
    #2;
    cmp("reset_outputs");
`ifdef HAZARD_STALL_STATS_EN
    chk_stats("reset_stats", 16'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("idle", ev(EN_ALL, 1'b0, 1'b0, 1'b0, RUN));

    // Load-use on Rs: one-cycle stall.
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    step("lu_rs_stall", ev(EN_LU, 1'b1, 1'b0, 1'b0, RUN));
    drive(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
    step("lu_rs_release", ev(EN_ALL, 1'b0, 1'b0, 1'b0, RUN));

    // Memory wait of three frozen cycles; branch+loaduse ignored while waiting.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step("mw_enter", ev(EN_NONE, 1'b0, 1'b0, 1'b0, RUN));
    step("mw_wait1", ev(EN_NONE, 1'b0, 1'b0, 1'b0, MW));
    drive(5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0);
    step("mw_ignore_br_lu", ev(EN_NONE, 1'b0, 1'b0, 1'b0, MW));
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    step("mw_ready", ev(EN_ALL, 1'b0, 1'b0, 1'b0, MW));
`ifdef HAZARD_STALL_STATS_EN
    chk_stats("stats_after_lu_mw", 16'd4);
`endif
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("mw_back_run", ev(EN_ALL, 1'b0, 1'b0, 1'b0, RUN));

    // Register 0 and Rt-only cases.
    drive(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    step("lu_reg0", ev(EN_ALL, 1'b0, 1'b0, 1'b0, RUN));
    drive(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    step("lu_rt_unused", ev(EN_ALL, 1'b0, 1'b0, 1'b0, RUN));
    drive(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    step("lu_rt_used", ev(EN_LU, 1'b1, 1'b0, 1'b0, RUN));
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("lu_rt_release", ev(EN_ALL, 1'b0, 1'b0, 1'b0, RUN));

    // Branch beats a simultaneous load-use; two flush cycles.
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    step("br_over_lu", ev(EN_ALL, 1'b0, 1'b1, 1'b0, RUN));
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("br_flush2", ev(EN_ALL, 1'b0, 1'b1, 1'b0, FL));
    step("br_done", ev(EN_ALL, 1'b0, 1'b0, 1'b0, RUN));

    // Memory stall inside FLUSH freezes in place.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    step("fl_ms_branch", ev(EN_ALL, 1'b0, 1'b1, 1'b0, RUN));
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step("fl_ms_frozen", ev(EN_NONE, 1'b0, 1'b0, 1'b0, FL));
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("fl_ms_resume", ev(EN_ALL, 1'b0, 1'b1, 1'b0, FL));
    step("fl_ms_done", ev(EN_ALL, 1'b0, 1'b0, 1'b0, RUN));

    // Branch inside FLUSH reloads the counter.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    step("fl_rl_branch", ev(EN_ALL, 1'b0, 1'b1, 1'b0, RUN));
    step("fl_rl_reload", ev(EN_ALL, 1'b0, 1'b1, 1'b0, FL));
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("fl_rl_last", ev(EN_ALL, 1'b0, 1'b1, 1'b0, FL));
    step("fl_rl_done", ev(EN_ALL, 1'b0, 1'b0, 1'b0, RUN));

    // Timeout: flag sets after the 4th MEM_WAIT cycle and is sticky.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step("to_enter", ev(EN_NONE, 1'b0, 1'b0, 1'b0, RUN));
    step("to_wait1", ev(EN_NONE, 1'b0, 1'b0, 1'b0, MW));
    step("to_wait2", ev(EN_NONE, 1'b0, 1'b0, 1'b0, MW));
    step("to_wait3", ev(EN_NONE, 1'b0, 1'b0, 1'b0, MW));
    step("to_wait4", ev(EN_NONE, 1'b0, 1'b0, 1'b0, MW));
    step("to_set", ev(EN_NONE, 1'b0, 1'b0, 1'b1, MW));
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    step("to_ready", ev(EN_ALL, 1'b0, 1'b0, 1'b1, MW));
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("to_sticky_run", ev(EN_ALL, 1'b0, 1'b0, 1'b1, RUN));

    // Reset asserted mid-wait aborts immediately.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step("rst_enter", ev(EN_NONE, 1'b0, 1'b0, 1'b1, RUN));
    step("rst_waiting", ev(EN_NONE, 1'b0, 1'b0, 1'b1, MW));
    reset = 1'b1;
    exp_q.push_back(ev(EN_NONE, 1'b0, 1'b0, 1'b0, RUN));
    #1;
    cmp("rst_async_abort");
`ifdef HAZARD_STALL_STATS_EN
    chk_stats("rst_stats_clear", 16'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("post_reset_idle", ev(EN_ALL, 1'b0, 1'b0, 1'b0, RUN));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
